decode_stage_hz: RTL and testbench

- Parametrised decode stage for the 16-bit, 4-bit-opcode pipelined core.
- Contains the register file, the flag register, branch resolution and a counter-based hazard unit that inserts multi-cycle bubbles.
- Owns the registered ID/EX pipeline register.
- Sits between the IF/ID register and the execute stage. Drives stall and flush back to fetch.

---
 rtl/decode_stage_hz.sv | 244 ++++++++++++++++++++++++
 tb/tb_decode_stage_hz.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_hz.sv
// Decode stage: register file, flags, branch resolution, counter-based hazard unit, ID/EX register.
// Optional macro DECODE_WB_BYPASS_EN forwards the write port into same-cycle reads.
`timescale 1ns/1ps
module decode_stage_hz #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int LOAD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [15:0]       if_instr,
  input  logic [DATA_W-1:0] if_pc,
  input  logic              ex_valid,
  input  logic [3:0]        ex_opcode,
  input  logic [3:0]        ex_dst,
  input  logic              mem_valid,
  input  logic [3:0]        mem_opcode,
  input  logic [3:0]        mem_dst,
  input  logic              wb_en,
  input  logic [3:0]        wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [2:0]        flag_en,
  input  logic [2:0]        flags_alu,
  output logic              stall,
  output logic              flush,
  output logic [DATA_W-1:0] branch_pc,
  output logic              hlt,
  output logic [2:0]        flags,
  output logic              id_ex_valid,
  output logic [15:0]       id_ex_instr,
  output logic [DATA_W-1:0] id_ex_rs_data,
  output logic [DATA_W-1:0] id_ex_rt_data,
  output logic [DATA_W-1:0] id_ex_imm,
  output logic [DATA_W-1:0] id_ex_pc_next,
  output logic              id_ex_reg_write,
  output logic              id_ex_mem_read,
  output logic              id_ex_mem_write,
  output logic              id_ex_load_hi,
  output logic              id_ex_load_lo
);

  typedef enum logic [1:0] {RUN, STALL, HALT} state_t;

  localparam logic [15:0] NOP = 16'hE000;
  localparam logic [2:0]  EX_LL = 3'(LOAD_LAT);
  localparam logic [2:0]  EX_BR = 3'(LOAD_LAT + 1);
`ifdef DECODE_WB_BYPASS_EN
  localparam logic [2:0]  MEM_LL = 3'(LOAD_LAT - 1);
  localparam logic [2:0]  MEM_BR = 3'(LOAD_LAT);
`else
  localparam logic [2:0]  MEM_LL = 3'(LOAD_LAT);
  localparam logic [2:0]  MEM_BR = 3'(LOAD_LAT + 1);
`endif

  state_t state, state_n;
  logic [2:0] cnt, cnt_n, hz_n, mem_n;
  logic [NUM_REGS-1:0][DATA_W-1:0] rf;

  logic [3:0] op, rs_a, rt_a;
  logic is_alu, is_lw, is_sw, is_llb, is_lhb;
  logic is_b, is_br, is_pcs, is_hlt;
  logic use_rs, use_rt, has_dst;
  logic [DATA_W-1:0] rs_data, rt_data, imm;
  logic [DATA_W-1:0] pc_inc, b_tgt;
  logic [2:0] ccc;
  logic cond_ok, taken, issue;
  logic ex_hit, mem_hit, ex_lw, mem_lw, ex_wr, flag_hz;

  assign op     = if_instr[15:12];
  assign ccc    = if_instr[11:9];
  assign is_alu = ~op[3];
  assign is_lw  = op == 4'h8;
  assign is_sw  = op == 4'h9;
  assign is_llb = op == 4'hA;
  assign is_lhb = op == 4'hB;
  assign is_b   = op == 4'hC;
  assign is_br  = op == 4'hD;
  assign is_pcs = op == 4'hE;
  assign is_hlt = op == 4'hF;

  assign use_rs  = is_alu | is_lw | is_sw | is_llb | is_lhb | is_br;
  assign use_rt  = is_alu | is_sw;
  assign has_dst = is_alu | is_lw | is_llb | is_lhb | is_pcs;
  assign rs_a    = (is_llb | is_lhb) ? if_instr[11:8] : if_instr[7:4];
  assign rt_a    = is_sw ? if_instr[11:8] : if_instr[3:0];

  always_comb begin
    imm = '0;
    unique case (1'b1)
      is_lw | is_sw: imm = DATA_W'({if_instr[3:0], 1'b0});
      is_llb:        imm = DATA_W'(if_instr[7:0]);
      is_lhb:        imm = DATA_W'({if_instr[7:0], 8'h00});
      default:       imm = DATA_W'(if_instr[3:0]);
    endcase
  end

  // rf[0] is never written, so address 0 reads zero
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rs_a == 4'(i)) rs_data = rf[i];
      if (rt_a == 4'(i)) rt_data = rf[i];
    end
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && wb_dst != 4'd0 && int'(wb_dst) < NUM_REGS) begin
      if (rs_a == wb_dst) rs_data = wb_data;
      if (rt_a == wb_dst) rt_data = wb_data;
    end
`endif
  end

  always_comb begin
    cond_ok = 1'b0;
    unique case (ccc)
      3'b000: cond_ok = ~flags[2];
      3'b001: cond_ok = flags[2];
      3'b010: cond_ok = ~flags[2] & ~flags[0];
      3'b011: cond_ok = flags[0];
      3'b100: cond_ok = flags[2] | ~flags[0];
      3'b101: cond_ok = flags[0] | flags[2];
      3'b110: cond_ok = flags[1];
      3'b111: cond_ok = 1'b1;
    endcase
  end

  assign pc_inc    = if_pc + DATA_W'(2);
  assign b_tgt     = pc_inc
                   + {{(DATA_W-10){if_instr[8]}}, if_instr[8:0], 1'b0};
  assign taken     = (is_b | is_br) & cond_ok;
  assign branch_pc = !taken ? pc_inc : (is_br ? rs_data : b_tgt);

  assign ex_lw  = ex_opcode == 4'h8;
  assign mem_lw = mem_opcode == 4'h8;
  assign ex_wr  = ~ex_opcode[3] | (ex_opcode == 4'hA)
                | (ex_opcode == 4'hB) | (ex_opcode == 4'hE);
  assign ex_hit = ex_valid && ex_dst != 4'd0
                && ((use_rs && ex_dst == rs_a)
                 || (use_rt && ex_dst == rt_a));
  assign mem_hit = mem_valid && mem_dst != 4'd0
                 && ((use_rs && mem_dst == rs_a)
                  || (use_rt && mem_dst == rt_a));
  // an ALU op in EX has not yet written the flags
  assign flag_hz = (is_b | is_br) && ccc != 3'b111
                 && ex_valid && !ex_opcode[3];
  assign mem_n = is_br ? MEM_BR : MEM_LL;

  always_comb begin
    hz_n = 3'd0;
    if (ex_hit && ex_lw) hz_n = is_br ? EX_BR : EX_LL;
    if (mem_hit && mem_lw && mem_n > hz_n) hz_n = mem_n;
    if (hz_n == 3'd0 && ((is_br && ex_hit && ex_wr) || flag_hz))
      hz_n = 3'd1;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stall   = 1'b0;
    flush   = 1'b0;
    issue   = 1'b0;
    unique case (state)
      RUN: begin
        if (if_valid && cnt == 3'd0) begin
          if (hz_n != 3'd0) begin
            stall = 1'b1;
            cnt_n = hz_n - 3'd1;
            if (hz_n > 3'd1) state_n = STALL;
          end else begin
            issue = 1'b1;
            flush = taken;
            if (is_hlt) state_n = HALT;
          end
        end
      end
      STALL: begin
        stall = 1'b1;
        if (cnt != 3'd0) cnt_n = cnt - 3'd1;
        if (cnt <= 3'd1) state_n = RUN;
      end
      HALT: stall = 1'b1;
      default: state_n = RUN;
    endcase
  end

  assign hlt = state == HALT;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= 3'd0;
      flags <= 3'd0;
      rf    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      flags <= (flags & ~flag_en) | (flags_alu & flag_en);
      for (int i = 1; i < NUM_REGS; i++)
        if (wb_en && wb_dst == 4'(i)) rf[i] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_ex_valid     <= 1'b0;
      id_ex_instr     <= NOP;
      id_ex_rs_data   <= '0;
      id_ex_rt_data   <= '0;
      id_ex_imm       <= '0;
      id_ex_pc_next   <= '0;
      id_ex_reg_write <= 1'b0;
      id_ex_mem_read  <= 1'b0;
      id_ex_mem_write <= 1'b0;
      id_ex_load_hi   <= 1'b0;
      id_ex_load_lo   <= 1'b0;
    end else if (issue) begin
      id_ex_valid     <= 1'b1;
      id_ex_instr     <= if_instr;
      id_ex_rs_data   <= rs_data;
      id_ex_rt_data   <= rt_data;
      id_ex_imm       <= imm;
      id_ex_pc_next   <= pc_inc;
      id_ex_reg_write <= has_dst;
      id_ex_mem_read  <= is_lw;
      id_ex_mem_write <= is_sw;
      id_ex_load_hi   <= is_lhb;
      id_ex_load_lo   <= is_llb;
    end else begin
      id_ex_valid     <= 1'b0;
      id_ex_instr     <= NOP;
      id_ex_rs_data   <= '0;
      id_ex_rt_data   <= '0;
      id_ex_imm       <= '0;
      id_ex_pc_next   <= '0;
      id_ex_reg_write <= 1'b0;
      id_ex_mem_read  <= 1'b0;
      id_ex_mem_write <= 1'b0;
      id_ex_load_hi   <= 1'b0;
      id_ex_load_lo   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage_hz.sv
// Directed scoreboard bench for decode_stage_hz (LOAD_LAT=2 instance).
// Expected ID/EX contents are queued when an instruction is presented.
`timescale 1ns/1ps
module tb_decode_stage_hz;

  localparam int LL = 2;
`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int MEM_STALLS = BYP ? LL - 1 : LL;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] rs;
    logic [15:0] rt;
    logic [15:0] imm;
    logic [15:0] pcn;
    logic [4:0]  ctl;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic if_valid;
  logic [15:0] if_instr, if_pc;
  logic ex_valid, mem_valid, wb_en;
  logic [3:0] ex_opcode, ex_dst, mem_opcode, mem_dst, wb_dst;
  logic [15:0] wb_data;
  logic [2:0] flag_en, flags_alu, flags;
  logic stall, flush, hlt;
  logic [15:0] branch_pc;
  logic id_ex_valid;
  logic [15:0] id_ex_instr, id_ex_rs_data, id_ex_rt_data;
  logic [15:0] id_ex_imm, id_ex_pc_next;
  logic id_ex_reg_write, id_ex_mem_read, id_ex_mem_write;
  logic id_ex_load_hi, id_ex_load_lo;

  exp_t sb[$];
  int n_tot = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decode_stage_hz #(.DATA_W(16), .NUM_REGS(16), .LOAD_LAT(LL)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_dst(ex_dst),
    .mem_valid(mem_valid), .mem_opcode(mem_opcode),
    .mem_dst(mem_dst),
    .wb_en(wb_en), .wb_dst(wb_dst), .wb_data(wb_data),
    .flag_en(flag_en), .flags_alu(flags_alu),
    .stall(stall), .flush(flush), .branch_pc(branch_pc),
    .hlt(hlt), .flags(flags),
    .id_ex_valid(id_ex_valid), .id_ex_instr(id_ex_instr),
    .id_ex_rs_data(id_ex_rs_data),
    .id_ex_rt_data(id_ex_rt_data),
    .id_ex_imm(id_ex_imm), .id_ex_pc_next(id_ex_pc_next),
    .id_ex_reg_write(id_ex_reg_write),
    .id_ex_mem_read(id_ex_mem_read),
    .id_ex_mem_write(id_ex_mem_write),
    .id_ex_load_hi(id_ex_load_hi),
    .id_ex_load_lo(id_ex_load_lo)
  );

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_tot++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // called at posedge+1; checks comb outputs, then ID/EX after the edge
  task automatic cyc(input string tag, input logic es,
                     input logic ef, input logic ev);
    exp_t e;
    #1;
    chk({tag, ".stall"}, 16'(stall), 16'(es));
    chk({tag, ".flush"}, 16'(flush), 16'(ef));
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, 16'(id_ex_valid), 16'(ev));
    if (!ev) begin
      chk({tag, ".bubble"}, id_ex_instr, 16'hE000);
    end else if (id_ex_valid && sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".instr"}, id_ex_instr, e.instr);
      chk({tag, ".rs"}, id_ex_rs_data, e.rs);
      chk({tag, ".rt"}, id_ex_rt_data, e.rt);
      chk({tag, ".imm"}, id_ex_imm, e.imm);
      chk({tag, ".pcn"}, id_ex_pc_next, e.pcn);
      chk({tag, ".ctl"},
          16'({id_ex_reg_write, id_ex_mem_read, id_ex_mem_write,
               id_ex_load_hi, id_ex_load_lo}), 16'(e.ctl));
    end
  endtask

  task automatic issue(input string tag, input logic [15:0] ins,
                       input logic [15:0] pc, input logic [15:0] rs,
                       input logic [15:0] rt, input logic [15:0] imm,
                       input logic [4:0] ctl, input logic ef);
    if_valid = 1'b1;
    if_instr = ins;
    if_pc    = pc;
    sb.push_back('{ins, rs, rt, imm, pc + 16'd2, ctl});
    cyc(tag, 1'b0, ef, 1'b1);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    if_valid = 1'b0;
    wb_en = 1'b1;
    wb_dst = a;
    wb_data = d;
    @(posedge clk);
    #1;
    wb_en = 1'b0;
  endtask

  task automatic setf(input logic [2:0] en, input logic [2:0] v);
    if_valid = 1'b0;
    flag_en = en;
    flags_alu = v;
    @(posedge clk);
    #1;
    flag_en = 3'b000;
  endtask

  initial begin
    rst = 1'b0;
    if_valid = 1'b0; if_instr = 16'h0; if_pc = 16'h0;
    ex_valid = 1'b0; ex_opcode = 4'h0; ex_dst = 4'h0;
    mem_valid = 1'b0; mem_opcode = 4'h0; mem_dst = 4'h0;
    wb_en = 1'b0; wb_dst = 4'h0; wb_data = 16'h0;
    flag_en = 3'b000; flags_alu = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 16'(id_ex_valid), 16'd0);
    chk("rst.instr", id_ex_instr, 16'hE000);
    chk("rst.flags", 16'(flags), 16'd0);
    chk("rst.stall", 16'(stall), 16'd0);
    chk("rst.hlt", 16'(hlt), 16'd0);
    rst = 1'b1;

    wr(4'd3, 16'h1111);
    wr(4'd5, 16'h2222);
    wr(4'd2, 16'h0040);

    // LW in EX feeding an ADD
    if_valid = 1'b1; if_instr = 16'h0435; if_pc = 16'h0020;
    ex_valid = 1'b1; ex_opcode = 4'h8; ex_dst = 4'd3;
    cyc("lu_ex", 1'b1, 1'b0, 1'b0);
    ex_valid = 1'b0;
    for (int i = 1; i < LL; i++) cyc("lu_ex", 1'b1, 1'b0, 1'b0);
    issue("lu_ex", 16'h0435, 16'h0020, 16'h1111, 16'h2222,
          16'h0005, 5'b10000, 1'b0);

    // LW in MEM feeding the rt operand
    mem_valid = 1'b1; mem_opcode = 4'h8; mem_dst = 4'd5;
    cyc("lu_mem", 1'b1, 1'b0, 1'b0);
    mem_valid = 1'b0;
    for (int i = 1; i < MEM_STALLS; i++)
      cyc("lu_mem", 1'b1, 1'b0, 1'b0);
    issue("lu_mem", 16'h0435, 16'h0024, 16'h1111, 16'h2222,
          16'h0005, 5'b10000, 1'b0);

    // BR r2 behind LW r2: LL+1 bubbles
    if_valid = 1'b1; if_instr = 16'hDE20; if_pc = 16'h0030;
    ex_valid = 1'b1; ex_opcode = 4'h8; ex_dst = 4'd2;
    cyc("br_ld", 1'b1, 1'b0, 1'b0);
    ex_valid = 1'b0;
    for (int i = 1; i <= LL; i++) cyc("br_ld", 1'b1, 1'b0, 1'b0);
    #1;
    chk("br_ld.bpc", branch_pc, 16'h0040);
    issue("br_ld", 16'hDE20, 16'h0030, 16'h0040, 16'h0000,
          16'h0000, 5'b00000, 1'b1);

    // conditional B, Z=1 taken
    ex_opcode = 4'h8;
    setf(3'b100, 3'b111);
    chk("flags.z1", 16'(flags), 16'h0004);
    if_valid = 1'b1; if_instr = 16'hC3FE; if_pc = 16'h0010;
    #1;
    chk("b_z1.bpc", branch_pc, 16'h000E);
    issue("b_z1", 16'hC3FE, 16'h0010, 16'h0000, 16'h0000,
          16'h000E, 5'b00000, 1'b1);

    // Z=0 not taken
    setf(3'b100, 3'b011);
    chk("flags.z0", 16'(flags), 16'h0000);
    if_valid = 1'b1; if_instr = 16'hC3FE; if_pc = 16'h0010;
    #1;
    chk("b_z0.bpc", branch_pc, 16'h0012);
    issue("b_z0", 16'hC3FE, 16'h0010, 16'h0000, 16'h0000,
          16'h000E, 5'b00000, 1'b0);

    // conditional B behind an ALU op: one bubble
    ex_valid = 1'b1; ex_opcode = 4'h1; ex_dst = 4'd0;
    cyc("flag_hz", 1'b1, 1'b0, 1'b0);
    ex_valid = 1'b0;
    issue("flag_hz", 16'hC3FE, 16'h0010, 16'h0000, 16'h0000,
          16'h000E, 5'b00000, 1'b0);

    // unconditional B ignores the ALU op in EX
    ex_valid = 1'b1; ex_opcode = 4'h1; ex_dst = 4'd7;
    if_valid = 1'b1; if_instr = 16'hCE02; if_pc = 16'h0040;
    #1;
    chk("b_al.bpc", branch_pc, 16'h0046);
    issue("b_al", 16'hCE02, 16'h0040, 16'h0000, 16'h0040,
          16'h0002, 5'b00000, 1'b1);
    ex_valid = 1'b0;

    // write port vs same-cycle read
    wb_en = 1'b1; wb_dst = 4'd5; wb_data = 16'hBEEF;
    issue("byp", 16'h0450, 16'h0050, BYP ? 16'hBEEF : 16'h2222,
          16'h0000, 16'h0000, 5'b10000, 1'b0);
    wb_en = 1'b0;
    issue("byp_after", 16'h0450, 16'h0052, 16'hBEEF, 16'h0000,
          16'h0000, 5'b10000, 1'b0);

    issue("sw", 16'h9532, 16'h0060, 16'h1111, 16'hBEEF,
          16'h0004, 5'b00100, 1'b0);
    issue("lw", 16'h8431, 16'h0062, 16'h1111, 16'h0000,
          16'h0002, 5'b11000, 1'b0);
    issue("lhb", 16'hB612, 16'h0064, 16'h0000, 16'h0040,
          16'h1200, 5'b10010, 1'b0);
    issue("llb", 16'hA6FF, 16'h0066, 16'h0000, 16'h0000,
          16'h00FF, 5'b10001, 1'b0);

    wr(4'd0, 16'hFFFF);
    issue("r0", 16'h0400, 16'h0070, 16'h0000, 16'h0000,
          16'h0000, 5'b10000, 1'b0);

    // BR behind a non-load writer of its source
    if_valid = 1'b1; if_instr = 16'hDE20; if_pc = 16'h0074;
    ex_valid = 1'b1; ex_opcode = 4'h2; ex_dst = 4'd2;
    cyc("br_alu", 1'b1, 1'b0, 1'b0);
    ex_valid = 1'b0;
    issue("br_alu", 16'hDE20, 16'h0074, 16'h0040, 16'h0000,
          16'h0000, 5'b00000, 1'b1);

    setf(3'b011, 3'b011);
    chk("flags.nv", 16'(flags), 16'h0003);

    issue("hlt", 16'hF000, 16'h0080, 16'h0000, 16'h0000,
          16'h0000, 5'b00000, 1'b0);
    chk("hlt.set", 16'(hlt), 16'd1);
    for (int i = 0; i < 20; i++) cyc("halt", 1'b1, 1'b0, 1'b0);
    chk("hlt.hold", 16'(hlt), 16'd1);

    // asynchronous reset out of HALT
    if_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst2.hlt", 16'(hlt), 16'd0);
    chk("rst2.stall", 16'(stall), 16'd0);
    chk("rst2.valid", 16'(id_ex_valid), 16'd0);
    chk("rst2.instr", id_ex_instr, 16'hE000);
    chk("rst2.flags", 16'(flags), 16'd0);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    issue("rst_rf", 16'h0430, 16'h0090, 16'h0000, 16'h0000,
          16'h0000, 5'b10000, 1'b0);

    // reset in the middle of a stall leaves no residual bubbles
    if_valid = 1'b1; if_instr = 16'h0435; if_pc = 16'h00A0;
    ex_valid = 1'b1; ex_opcode = 4'h8; ex_dst = 4'd3;
    cyc("mid", 1'b1, 1'b0, 1'b0);
    ex_valid = 1'b0;
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    issue("post_rst", 16'h0435, 16'h00A0, 16'h0000, 16'h0000,
          16'h0005, 5'b10000, 1'b0);

    chk("sb.drained", 16'(sb.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
